// File: rtl/player_motion.sv
// player_motion: per-frame player motion controller for the platformer.
// Advances position, vertical velocity and life state once per frame_tick,
// using the collision flags sampled for the current position.
// Optional feature macro: PLAYER_MOTION_DOUBLE_JUMP_EN (one extra jump per
// airborne period). The default build leaves it undefined.

module player_motion #(
    parameter int SPAWN_X        = 20,
    parameter int SPAWN_Y_L1     = 344,
    parameter int SPAWN_Y_L2     = 384,
    parameter int PLAYER_H       = 16,
    parameter int PLAYER_W       = 16,
    parameter int WALK_SPEED     = 2,
    parameter int JUMP_VEL       = 9,
    parameter int GRAVITY        = 1,
    parameter int MAX_FALL       = 8,
    parameter int RESPAWN_FRAMES = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       level_start,
    input  logic [1:0] level,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_jump,
    input  logic       on_ground,
    input  logic [9:0] support_y,
    input  logic       hit_ceiling,
    input  logic       hit_left_wall,
    input  logic       hit_right_wall,
    input  logic       at_goal_region,
    input  logic       in_lava,
    output logic [9:0] player_x,
    output logic [9:0] player_y,
    output logic       facing,
    output logic [2:0] state,
    output logic       died,
    output logic       level_done,
    output logic [7:0] deaths
);

    typedef enum logic [2:0] {
        ST_SPAWN  = 3'd0,
        ST_GROUND = 3'd1,
        ST_AIR    = 3'd2,
        ST_DEAD   = 3'd3,
        ST_WON    = 3'd4
    } state_e;

    localparam logic [9:0]         SPAWN_X_C        = 10'(SPAWN_X);
    localparam logic [9:0]         SPAWN_Y1_C       = 10'(SPAWN_Y_L1);
    localparam logic [9:0]         SPAWN_Y2_C       = 10'(SPAWN_Y_L2);
    localparam logic [10:0]        WALK_C           = 11'(WALK_SPEED);
    localparam logic [10:0]        X_MAX_C          = 11'(640 - PLAYER_W);
    localparam logic signed [10:0] Y_MAX_C          = 11'sd464;
    localparam logic signed [10:0] PLAYER_H_C       = 11'(PLAYER_H);
    localparam logic signed [10:0] JUMP_DY_C        = 11'(JUMP_VEL);
    // The take-off frame is also the first airborne frame: the rise of
    // JUMP_VEL is applied immediately, so gravity is already folded into
    // the stored velocity (344 -> 335 -> 327 -> 320 for the defaults).
    localparam logic signed [5:0]  GROUND_JUMP_VY_C = 6'(GRAVITY - JUMP_VEL);
    localparam logic signed [6:0]  GRAVITY_C        = 7'(GRAVITY);
    localparam logic signed [6:0]  MAX_FALL_C       = 7'(MAX_FALL);
    localparam logic [4:0]         RESPAWN_LAST_C   = 5'(RESPAWN_FRAMES - 1);
`ifdef PLAYER_MOTION_DOUBLE_JUMP_EN
    localparam logic signed [5:0]  AIR_JUMP_VY_C    = 6'(-JUMP_VEL);
`endif

    // Registered state
    logic [9:0]        x_q, x_d;
    logic [9:0]        y_q, y_d;
    logic signed [5:0] vy_q, vy_d;
    state_e            state_q, state_d;
    logic              jump_prev_q, jump_prev_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [7:0]        deaths_q, deaths_d;
    logic              facing_q, facing_d;
    logic              died_q, died_d;
    logic              done_q, done_d;
`ifdef PLAYER_MOTION_DOUBLE_JUMP_EN
    logic              dj_used_q, dj_used_d;
`endif

    // Combinational helpers
    logic              jump_req_s;
    logic              left_only_s;
    logic              right_only_s;
    logic [10:0]       x_ext_s;
    logic [9:0]        x_left_s;
    logic [10:0]       x_right_sum_s;
    logic [9:0]        x_right_s;
    logic signed [10:0] y_ext_s;
    logic signed [10:0] vy_ext_s;
    logic signed [10:0] y_fall_s;
    logic signed [10:0] y_land_s;
    logic signed [10:0] y_jump_s;
    logic signed [6:0] vy_grav_sum_s;
    logic signed [5:0] vy_grav_s;
    logic [9:0]        spawn_y_s;
    logic [7:0]        deaths_inc_s;

    // Clamp an 11-bit signed row into the playfield: above the top pins to
    // row 0, below the lowest legal sprite row pins to 464.
    function automatic logic [9:0] clamp_y(input logic signed [10:0] r);
        logic [9:0] res;
        if (r[10]) begin
            res = 10'd0;
        end else if (r > Y_MAX_C) begin
            res = 10'(Y_MAX_C);
        end else begin
            res = r[9:0];
        end
        return res;
    endfunction

    assign jump_req_s    = btn_jump & ~jump_prev_q;
    assign left_only_s   = btn_left & ~btn_right;
    assign right_only_s  = btn_right & ~btn_left;

    assign x_ext_s       = {1'b0, x_q};
    assign x_left_s      = (x_ext_s >= WALK_C) ? (x_q - WALK_C[9:0]) : 10'd0;
    assign x_right_sum_s = x_ext_s + WALK_C;
    assign x_right_s     = (x_right_sum_s > X_MAX_C) ? X_MAX_C[9:0] : x_right_sum_s[9:0];

    assign y_ext_s       = signed'({1'b0, y_q});
    assign vy_ext_s      = signed'({{5{vy_q[5]}}, vy_q});
    assign y_fall_s      = y_ext_s + vy_ext_s;
    assign y_land_s      = signed'({1'b0, support_y}) - PLAYER_H_C;
    assign y_jump_s      = y_ext_s - JUMP_DY_C;

    assign vy_grav_sum_s = signed'({vy_q[5], vy_q}) + GRAVITY_C;
    assign vy_grav_s     = (vy_grav_sum_s > MAX_FALL_C) ? MAX_FALL_C[5:0] : vy_grav_sum_s[5:0];

    assign spawn_y_s     = (level == 2'd0) ? SPAWN_Y1_C : SPAWN_Y2_C;
    assign deaths_inc_s  = (deaths_q == 8'hFF) ? deaths_q : (deaths_q + 8'd1);

    // Next-state logic: level_start outranks frame_tick; otherwise hold
    always_comb begin
        x_d         = x_q;
        y_d         = y_q;
        vy_d        = vy_q;
        state_d     = state_q;
        jump_prev_d = jump_prev_q;
        cnt_d       = cnt_q;
        deaths_d    = deaths_q;
        facing_d    = facing_q;
        died_d      = 1'b0;
        done_d      = 1'b0;
`ifdef PLAYER_MOTION_DOUBLE_JUMP_EN
        dj_used_d   = dj_used_q;
`endif

        if (level_start) begin
            x_d     = SPAWN_X_C;
            y_d     = spawn_y_s;
            vy_d    = 6'sd0;
            state_d = ST_AIR;
            cnt_d   = 5'd0;
`ifdef PLAYER_MOTION_DOUBLE_JUMP_EN
            dj_used_d = 1'b0;
`endif
        end else if (frame_tick) begin
            jump_prev_d = btn_jump;
            case (state_q)
                ST_SPAWN: begin
                    state_d = ST_AIR;
                end
                ST_GROUND, ST_AIR: begin
                    if (left_only_s && !hit_left_wall) begin
                        x_d      = x_left_s;
                        facing_d = 1'b0;
                    end else if (right_only_s && !hit_right_wall) begin
                        x_d      = x_right_s;
                        facing_d = 1'b1;
                    end else begin
                        x_d      = x_q;
                        facing_d = facing_q;
                    end

                    if (in_lava) begin
                        state_d  = ST_DEAD;
                        died_d   = 1'b1;
                        deaths_d = deaths_inc_s;
                        cnt_d    = 5'd0;
                    end else if (at_goal_region) begin
                        state_d = ST_WON;
                        done_d  = 1'b1;
                    end else if (state_q == ST_GROUND) begin
                        if (jump_req_s) begin
                            state_d = ST_AIR;
                            y_d     = clamp_y(y_jump_s);
                            vy_d    = y_jump_s[10] ? 6'sd0 : GROUND_JUMP_VY_C;
                        end else if (!on_ground) begin
                            state_d = ST_AIR;
                            vy_d    = 6'sd0;
                        end else begin
                            y_d  = clamp_y(y_land_s);
                            vy_d = y_land_s[10] ? 6'sd0 : vy_q;
                        end
                    end else begin
                        if (on_ground && !vy_q[5]) begin
                            state_d = ST_GROUND;
                            y_d     = clamp_y(y_land_s);
                            vy_d    = 6'sd0;
`ifdef PLAYER_MOTION_DOUBLE_JUMP_EN
                            dj_used_d = 1'b0;
`endif
                        end else if (hit_ceiling && vy_q[5]) begin
                            vy_d = 6'sd0;
`ifdef PLAYER_MOTION_DOUBLE_JUMP_EN
                        end else if (jump_req_s && !dj_used_q) begin
                            vy_d      = AIR_JUMP_VY_C;
                            dj_used_d = 1'b1;
`endif
                        end else begin
                            y_d  = clamp_y(y_fall_s);
                            vy_d = y_fall_s[10] ? 6'sd0 : vy_grav_s;
                        end
                    end
                end
                ST_DEAD: begin
                    if (cnt_q == RESPAWN_LAST_C) begin
                        x_d     = SPAWN_X_C;
                        y_d     = spawn_y_s;
                        vy_d    = 6'sd0;
                        state_d = ST_AIR;
                        cnt_d   = 5'd0;
`ifdef PLAYER_MOTION_DOUBLE_JUMP_EN
                        dj_used_d = 1'b0;
`endif
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                ST_WON: begin
                    state_d = ST_WON;
                end
                default: begin
                    state_d = ST_SPAWN;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State register with synchronous reset to spawn defaults
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q         <= SPAWN_X_C;
            y_q         <= SPAWN_Y1_C;
            vy_q        <= 6'sd0;
            state_q     <= ST_SPAWN;
            jump_prev_q <= 1'b0;
            cnt_q       <= 5'd0;
            deaths_q    <= 8'd0;
            facing_q    <= 1'b1;
            died_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef PLAYER_MOTION_DOUBLE_JUMP_EN
            dj_used_q   <= 1'b0;
`endif
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            vy_q        <= vy_d;
            state_q     <= state_d;
            jump_prev_q <= jump_prev_d;
            cnt_q       <= cnt_d;
            deaths_q    <= deaths_d;
            facing_q    <= facing_d;
            died_q      <= died_d;
            done_q      <= done_d;
`ifdef PLAYER_MOTION_DOUBLE_JUMP_EN
            dj_used_q   <= dj_used_d;
`endif
        end
    end

    assign player_x   = x_q;
    assign player_y   = y_q;
    assign facing     = facing_q;
    assign state      = state_q;
    assign died       = died_q;
    assign level_done = done_q;
    assign deaths     = deaths_q;

endmodule

// File: doc/player_motion.md
# player_motion

Per-frame player motion controller for the platformer datapath. It closes the loop with `platform_collision`: it drives `player_x`/`player_y` into the collision block and consumes that block's support, wall, ceiling, goal and lava flags to advance position, vertical velocity and life state once per video frame. It sits between the button synchronisers and the renderer/game-flow controller, which consume its death and level-complete pulses.

## Interface
Parameters:
- `SPAWN_X`, 20: spawn column, both levels.
- `SPAWN_Y_L1`, 344: level 0 spawn row (feet on y=360).
- `SPAWN_Y_L2`, 384: level 1 spawn row (feet on y=400).
- `PLAYER_H`, 16: sprite height; `PLAYER_W`, 16: sprite width.
- `WALK_SPEED`, 2: pixels per frame horizontally.
- `JUMP_VEL`, 9: initial upward speed, pixels/frame (≤ 15).
- `GRAVITY`, 1: vy increment per frame.
- `MAX_FALL`, 8: terminal downward vy.
- `RESPAWN_FRAMES`, 30: frames held in DEAD before respawn.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `frame_tick` in 1: one-cycle pulse per frame; all motion updates gated by it.
- `level_start` in 1: one-cycle pulse; load spawn for `level`.
- `level` in 2: 0 = level 1, 1 = level 2.
- `btn_left`, `btn_right`, `btn_jump` in 1 each: already synchronous to `clk`.
- `on_ground` in 1, `support_y` in 10, `hit_ceiling` in 1, `hit_left_wall` in 1, `hit_right_wall` in 1, `at_goal_region` in 1, `in_lava` in 1: collision flags for the current position.
- `player_x` out 10, `player_y` out 10: top-left of sprite.
- `facing` out 1: 1 = right.
- `state` out 3: SPAWN=0, GROUND=1, AIR=2, DEAD=3, WON=4.
- `died` out 1, `level_done` out 1: one-cycle pulses.
- `deaths` out 8: saturating death count.

## Operation
- Registers: x, y, signed 6-bit `vy` (negative = up), state, `jump_prev`, 5-bit frame counter, deaths.
- Priority per clock: `reset` > `level_start` > `frame_tick` > hold.
- `level_start`: x=SPAWN_X, y=SPAWN_Y_L1 if `level`==0, else SPAWN_Y_L2; vy=0; state=AIR; counter=0; `deaths` retained.
- Jump request = `btn_jump && !jump_prev`. `jump_prev` loads `btn_jump` on each `frame_tick` only.
- Horizontal, GROUND and AIR only:
  - left-only and `!hit_left_wall`: x = max(x−WALK_SPEED, 0), facing=0.
  - right-only and `!hit_right_wall`: x = min(x+WALK_SPEED, 640−PLAYER_W), facing=1.
  - both or neither: x held, facing held.
- GROUND, evaluated in order:
  - `in_lava` → DEAD.
  - `at_goal_region` → WON.
  - jump request → AIR, vy=−JUMP_VEL, y=y−JUMP_VEL.
  - `!on_ground` → AIR, vy=0.
  - else y = support_y−PLAYER_H.
- AIR, evaluated in order:
  - `in_lava` → DEAD.
  - `at_goal_region` → WON.
  - `on_ground && vy≥0` → GROUND, y=support_y−PLAYER_H, vy=0.
  - `hit_ceiling && vy<0` → vy=0, y held.
  - else y=y+vy, vy=min(vy+GRAVITY, MAX_FALL).
- Y arithmetic is 11-bit signed:
  - result <0 → y=0, vy=0.
  - result >464 → y=464.
- DEAD:
  - x, y frozen; `died`=1 for the entry cycle; `deaths` increments, saturating at 255; counter=0.
  - Each tick increments the counter. At RESPAWN_FRAMES−1, reload spawn as `level_start` does and go to AIR.
- WON:
  - frozen; `level_done`=1 for the entry cycle; held until `level_start` or `reset`.
- SPAWN: entered only by `reset`; first `frame_tick` → AIR, no motion that frame.

## Timing
- All outputs registered. Updates land on the `clk` edge where `frame_tick`=1; collision inputs are sampled on that same edge.
- `died` and `level_done` are high exactly one clock, the cycle after the transitioning edge.
- Reset values:
  - `player_x`=SPAWN_X, `player_y`=SPAWN_Y_L1, `facing`=1, `state`=SPAWN.
  - `died`=0, `level_done`=0, `deaths`=0, vy=0, `jump_prev`=0.
- `level_start` coincident with `frame_tick`: spawn load only, no motion.
- `frame_tick` high on consecutive clocks: each counts as a frame.

## Configuration
- `PLAYER_MOTION_DOUBLE_JUMP_EN`:
  - Defined: one extra jump per airborne period. An AIR jump request with the extra jump unused sets vy=−JUMP_VEL and marks it used; ceiling/landing rules unchanged. The flag clears on GROUND entry and on spawn.
  - Undefined: AIR ignores jump requests.

## Test plan
- Reset, `level_start` with `level`=0, `on_ground`=1, `support_y`=360, 3 ticks → state GROUND, y=344, x=20.
- GROUND, `btn_right` held 5 ticks, no walls → x=30, facing=1. With `hit_right_wall`=1 → x held at 30.
- GROUND, jump pressed, `on_ground` forced 0 afterward → per-tick y: 335, 327, 320 (vy −9→−8→−7). Then `hit_ceiling`=1 → vy=0, next tick y+0, vy=1.
- AIR, `in_lava`=1 and `at_goal_region`=1 on the same tick → DEAD, `died` one-cycle pulse, `deaths`=1. After 30 ticks → x=20, y=344, state AIR.
- GROUND, `at_goal_region`=1 → WON, `level_done` one pulse. Buttons for 10 ticks → x, y unchanged. `level_start` with `level`=1 → y=384.
- With macro: two jump presses while airborne → second applies vy=−9, third is ignored. Without macro: second press ignored.
